// File: rtl/ens_vote_pkg.sv
// ens_vote_pkg: shared state encoding and width helpers for the ensemble vote/argmax stage.
// Provides state_t {ACCUM, SCAN, OUT}, sum_w() for the accumulator width and idx_w() for the class index width.
package ens_vote_pkg;
    typedef enum logic [1:0] {ACCUM, SCAN, OUT} state_t;
    // Smallest width that holds NUM_ENS maximal scores added together, so sums can never overflow.
    function automatic int sum_w(input int n_ens, input int cbits);
        return $clog2(n_ens * (2 ** cbits - 1) + 1);
    endfunction
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ens_vote_argmax_if.sv
// ens_vote_argmax_if: input member-vector and output result handshakes of the vote/argmax stage.
// master (producer/consumer side): drives in_data, in_valid, out_ready; sees in_ready, out_class, out_score, out_valid.
// slave (block side): the mirror image.
interface ens_vote_argmax_if
    import ens_vote_pkg::*;
#(
    parameter int NUM_CLASSES = 10,
    parameter int CLASS_BITS  = 2,
    parameter int NUM_ENS     = 4
);
    localparam int SUM_W = sum_w(NUM_ENS, CLASS_BITS);
    localparam int IDX_W = idx_w(NUM_CLASSES);
    logic [NUM_CLASSES*CLASS_BITS-1:0] in_data;
    logic                              in_valid;
    logic                              in_ready;
    logic [IDX_W-1:0]                  out_class;
    logic [SUM_W-1:0]                  out_score;
    logic                              out_valid;
    logic                              out_ready;
    modport master (output in_data, in_valid, out_ready, input in_ready, out_class, out_score, out_valid);
    modport slave  (input in_data, in_valid, out_ready, output in_ready, out_class, out_score, out_valid);
endinterface

// File: rtl/ens_class_acc.sv
// ens_class_acc: NUM_CLASSES x SUM_W per-class accumulator array with add-vector, clear and an indexed read port.
// Ports: clk, rst (sync, active-high), clr (clear all), add (add vec fieldwise), vec (packed class scores),
//        rd_idx (class to read), rd_data (acc[rd_idx], combinational).
module ens_class_acc
    import ens_vote_pkg::*;
#(
    parameter int NUM_CLASSES = 10,
    parameter int CLASS_BITS  = 2,
    parameter int SUM_W       = 4,
    parameter int IDX_W       = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clr,
    input  logic                              add,
    input  logic [NUM_CLASSES*CLASS_BITS-1:0] vec,
    input  logic [IDX_W-1:0]                  rd_idx,
    output logic [SUM_W-1:0]                  rd_data
);
    logic [SUM_W-1:0] acc [NUM_CLASSES];
    always_ff @(posedge clk) begin
        if (rst || clr)
            for (int c = 0; c < NUM_CLASSES; c++) acc[c] <= '0;
        else if (add)
            for (int c = 0; c < NUM_CLASSES; c++) acc[c] <= acc[c] + SUM_W'(vec[c*CLASS_BITS +: CLASS_BITS]);
    end
    assign rd_data = acc[rd_idx];
endmodule

// File: rtl/ens_vote_argmax.sv
// ens_vote_argmax: sums per-class scores over NUM_ENS ensemble members, then scans the sums and emits the argmax.
// Ports: clk, rst (sync, active-high), bus (ens_vote_argmax_if.slave: in_data/in_valid/in_ready member input,
//        out_class/out_score/out_valid/out_ready result output).
module ens_vote_argmax
    import ens_vote_pkg::*;
#(
    parameter int NUM_CLASSES = 10,
    parameter int CLASS_BITS  = 2,
    parameter int NUM_ENS     = 4
) (
    input logic               clk,
    input logic               rst,
    ens_vote_argmax_if.slave  bus
);
    localparam int SUM_W = sum_w(NUM_ENS, CLASS_BITS);
    localparam int IDX_W = idx_w(NUM_CLASSES);
    localparam int CNT_W = NUM_ENS > 1 ? $clog2(NUM_ENS) : 1;
    state_t           state, state_nx;
    logic [CNT_W-1:0] mcnt;
    logic [IDX_W-1:0] sidx, best_idx, out_class;
    logic [SUM_W-1:0] best, out_score, rd_data;
    logic             out_valid, in_acc, last_mem, last_cls, take, out_hs;
    ens_class_acc #(
        .NUM_CLASSES(NUM_CLASSES), .CLASS_BITS(CLASS_BITS), .SUM_W(SUM_W), .IDX_W(IDX_W)
    ) u_acc (
        .clk(clk), .rst(rst), .clr(out_hs), .add(in_acc),
        .vec(bus.in_data), .rd_idx(sidx), .rd_data(rd_data)
    );
    always_comb begin
        in_acc   = state == ACCUM && bus.in_valid;
        last_mem = mcnt == CNT_W'(NUM_ENS - 1);
        last_cls = sidx == IDX_W'(NUM_CLASSES - 1);
        // Strict compare keeps the lowest index on ties; class 0 always seeds the running best.
        take     = sidx == '0 || rd_data > best;
        out_hs   = state == OUT && bus.out_ready;
        state_nx = (in_acc && last_mem)          ? SCAN  :
                   (state == SCAN && last_cls)   ? OUT   :
                   out_hs                        ? ACCUM : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            mcnt      <= '0;
            sidx      <= '0;
            best      <= '0;
            best_idx  <= '0;
            out_valid <= 1'b0;
            out_class <= '0;
            out_score <= '0;
        end else begin
            state <= state_nx;
            if (in_acc) begin
                mcnt <= last_mem ? '0 : mcnt + 1'b1;
                sidx <= '0;
            end
            if (state == SCAN) begin
                sidx <= sidx + 1'b1;
                if (take) begin
                    best     <= rd_data;
                    best_idx <= sidx;
                end
                if (last_cls) begin
                    out_class <= take ? sidx : best_idx;
                    out_score <= take ? rd_data : best;
                    out_valid <= 1'b1;
                end
            end
            if (out_hs) out_valid <= 1'b0;
        end
    end
    assign bus.in_ready  = state == ACCUM;
    assign bus.out_valid = out_valid;
    assign bus.out_class = out_class;
    assign bus.out_score = out_score;
endmodule

// File: tb/tb_ens_vote_argmax.sv
// tb_ens_vote_argmax: scoreboard bench for ens_vote_argmax with default parameters.
module tb_ens_vote_argmax;
    localparam int NC = 10;
    localparam int CB = 2;
    localparam int NE = 4;
    localparam int DW = NC * CB;
    typedef logic [DW-1:0] vec_t;
    typedef struct { int cls; int score; } exp_t;
    logic clk = 0;
    logic rst = 1;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    vec_t m [NE];
    vec_t mr [NE];
    ens_vote_argmax_if #(.NUM_CLASSES(NC), .CLASS_BITS(CB), .NUM_ENS(NE)) bus ();
    ens_vote_argmax #(.NUM_CLASSES(NC), .CLASS_BITS(CB), .NUM_ENS(NE)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    function automatic vec_t fld(input int c, input int v);
        vec_t r = '0;
        r[c*CB +: CB] = CB'(v);
        return r;
    endfunction
    // Reference model: plain per-class sums, first strict maximum wins.
    function automatic exp_t model(input vec_t mm [NE]);
        int   s [NC];
        exp_t e;
        for (int c = 0; c < NC; c++) begin
            s[c] = 0;
            for (int k = 0; k < NE; k++) s[c] += int'(mm[k][c*CB +: CB]);
        end
        e.cls = 0;
        e.score = s[0];
        for (int c = 1; c < NC; c++) if (s[c] > e.score) begin
            e.cls = c;
            e.score = s[c];
        end
        return e;
    endfunction
    task automatic send(input vec_t v, input int bub);
        repeat (bub) @(posedge clk);
        #1;
        chk("in_ready_accum", int'(bus.in_ready), 1);
        bus.in_data  = v;
        bus.in_valid = 1;
        @(posedge clk);
        #1;
        bus.in_valid = 0;
        bus.in_data  = '0;
    endtask
    task automatic run_batch(input vec_t mm [NE], input int bub_max, input int hold);
        int   cnt;
        exp_t e;
        sb.push_back(model(mm));
        for (int k = 0; k < NE; k++) send(mm[k], $urandom_range(0, bub_max));
        cnt = 0;
        while (!bus.out_valid && cnt < 100) begin
            chk("in_ready_scan", int'(bus.in_ready), 0);
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("latency", cnt, NC);
        e = sb.pop_front();
        chk("out_class", int'(bus.out_class), e.cls);
        chk("out_score", int'(bus.out_score), e.score);
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk("hold_valid", int'(bus.out_valid), 1);
            chk("hold_class", int'(bus.out_class), e.cls);
            chk("hold_score", int'(bus.out_score), e.score);
            chk("hold_in_ready", int'(bus.in_ready), 0);
        end
        bus.out_ready = 1;
        @(posedge clk);
        #1;
        bus.out_ready = 0;
        chk("hs_valid_low", int'(bus.out_valid), 0);
        chk("hs_in_ready", int'(bus.in_ready), 1);
    endtask
    initial begin
        bus.in_data   = '0;
        bus.in_valid  = 1;
        bus.out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        bus.in_valid  = 0;
        bus.out_ready = 0;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_class", int'(bus.out_class), 0);
        chk("rst_out_score", int'(bus.out_score), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        for (int k = 0; k < NE; k++) m[k] = fld(7, 3);
        run_batch(m, 0, 0);
        m[0] = fld(2, 3) | fld(5, 3) | fld(1, 2);
        m[1] = fld(2, 3) | fld(5, 3) | fld(8, 3);
        m[2] = fld(1, 3);
        m[3] = fld(8, 2);
        run_batch(m, 0, 0);
        for (int k = 0; k < NE; k++) m[k] = '0;
        run_batch(m, 0, 0);
        for (int k = 0; k < NE; k++) m[k] = fld(0, 1) | fld(3, 3);
        run_batch(m, 0, 20);
        for (int k = 0; k < NE; k++) m[k] = fld(9, 1);
        run_batch(m, 0, 0);
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < NE; k++) mr[k] = vec_t'({$urandom, $urandom});
            run_batch(mr, 0, 0);
            run_batch(mr, 3, $urandom_range(0, 2));
        end
        send(fld(3, 3), 0);
        send(fld(3, 3), 1);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        chk("midrst_in_ready", int'(bus.in_ready), 1);
        repeat (15) begin
            @(posedge clk);
            #1;
            chk("midrst_no_valid", int'(bus.out_valid), 0);
        end
        for (int k = 0; k < NE; k++) m[k] = fld(4, 1);
        run_batch(m, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
